// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for a 5-stage RISC-V pipeline.
// Generates stage-register enables/flushes, EX operand forwarding selects,
// the data-memory wait handshake, a post-reset hold window, a wait timeout
// and a stall performance counter.
module pipeline_ctrl #(
    parameter int unsigned INIT_CYCLES  = 4,
    parameter int unsigned WAIT_TIMEOUT = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_branch_taken,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic             mem_access,
    input  logic             dmem_ready,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic             dmem_req,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned INIT_W = 4;
    localparam int unsigned WAIT_W = 8;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [INIT_W-1:0]  init_cnt_q, init_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               timeout_set;
    logic               advance;
    logic               load_use;

    // Forwarding select for one EX operand; MEM result wins over WB result.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       m_we,
        input logic [4:0] m_rd,
        input logic       w_we,
        input logic [4:0] w_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
            sel = 2'b10;
        end else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Load in EX whose destination is read by the instruction in ID.
    always_comb begin
        load_use = ex_memread && (ex_rd != 5'd0) &&
                   (((ex_rd == id_rs1) && id_use_rs1) ||
                    ((ex_rd == id_rs2) && id_use_rs2));
    end

    // Next-state, counters and all pipeline control outputs.
    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_set   = 1'b0;
        advance       = 1'b0;
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b1;
        dmem_req      = 1'b0;
        fwd_a         = fwd_sel(ex_rs1, mem_regwrite, mem_rd, wb_regwrite, wb_rd);
        fwd_b         = fwd_sel(ex_rs2, mem_regwrite, mem_rd, wb_regwrite, wb_rd);

        case (state_q)
            ST_INIT: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (init_cnt_q == INIT_LAST) begin
                    state_d    = ST_RUN;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + INIT_W'(1);
                end
            end
            ST_RUN: begin
                dmem_req   = mem_access;
                wait_cnt_d = '0;
                if (mem_access && !dmem_ready) begin
                    state_d = ST_MEM_WAIT;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                dmem_req = mem_access;
                if (dmem_ready || (wait_cnt_q == WAIT_LAST)) begin
                    advance     = 1'b1;
                    wait_cnt_d  = '0;
                    state_d     = ST_RUN;
                    timeout_set = !dmem_ready;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // Normal flow: a taken branch squashes ID, so it masks load-use.
        if (advance) begin
            mem_wb_bubble = 1'b0;
            if (ex_branch_taken) begin
                pc_en       = 1'b1;
                if_id_en    = 1'b1;
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
                id_ex_flush = 1'b1;
            end else begin
                pc_en       = 1'b1;
                if_id_en    = 1'b1;
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
            end
        end

        // Reset overrides every control output immediately.
        if (!reset) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            if_id_flush   = 1'b0;
            id_ex_flush   = 1'b0;
            mem_wb_bubble = 1'b1;
            dmem_req      = 1'b0;
            fwd_a         = 2'b00;
            fwd_b         = 2'b00;
        end
    end

    // State and counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Sticky timeout flag and saturating stall counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timeout_err <= 1'b0;
            stall_count <= '0;
        end else begin
            if (timeout_set) begin
                timeout_err <= 1'b1;
            end
            if ((state_q != ST_INIT) && !pc_en && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios with literal
// expectations plus a cycle-by-cycle comparison against a behavioural model.
module tb_pipeline_ctrl;

    localparam int unsigned INIT_CYCLES  = 4;
    localparam int unsigned WAIT_TIMEOUT = 8;
    localparam int unsigned CNT_W        = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic [4:0]       id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic             id_use_rs1, id_use_rs2, ex_memread, ex_branch_taken;
    logic             mem_regwrite, mem_access, dmem_ready, wb_regwrite;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic             if_id_flush, id_ex_flush, mem_wb_bubble, dmem_req;
    logic [1:0]       fwd_a, fwd_b;
    logic             timeout_err;
    logic [CNT_W-1:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_ctrl #(
        .INIT_CYCLES (INIT_CYCLES),
        .WAIT_TIMEOUT(WAIT_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_rd          (ex_rd),
        .ex_memread     (ex_memread),
        .ex_branch_taken(ex_branch_taken),
        .mem_rd         (mem_rd),
        .mem_regwrite   (mem_regwrite),
        .mem_access     (mem_access),
        .dmem_ready     (dmem_ready),
        .wb_rd          (wb_rd),
        .wb_regwrite    (wb_regwrite),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .id_ex_en       (id_ex_en),
        .ex_mem_en      (ex_mem_en),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .mem_wb_bubble  (mem_wb_bubble),
        .dmem_req       (dmem_req),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .timeout_err    (timeout_err),
        .stall_count    (stall_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Model state: cycles spent in the hold window, whether a memory wait is
    // outstanding and how long it has lasted, sticky timeout, stall total.
    int          m_init  = 0, n_init  = 0;
    bit          m_wait  = 0, n_wait  = 0;
    int          m_wcnt  = 0, n_wcnt  = 0;
    bit          m_tmo   = 0, n_tmo   = 0;
    logic [31:0] m_stall = 0, n_stall = 0;

    logic [7:0]  e_ctrl;
    logic [3:0]  e_fwd;
    logic        e_tmo;
    logic [31:0] e_stall;
    bit          stuck, lu;

    function automatic logic [1:0] model_fwd(input logic [4:0] rs);
        if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 2'b10;
        if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Expected outputs for this cycle and the model's next state.
    always @(negedge clock) begin
        e_fwd = {model_fwd(ex_rs1), model_fwd(ex_rs2)};
        n_init = m_init; n_wait = m_wait; n_wcnt = m_wcnt; n_tmo = m_tmo; n_stall = m_stall;
        if (!reset) begin
            e_ctrl = 8'b0000_0010; e_fwd = 4'b0; e_tmo = 1'b0; e_stall = 32'd0;
            n_init = 0; n_wait = 0; n_wcnt = 0; n_tmo = 0; n_stall = 0;
        end else begin
            e_tmo   = m_tmo;
            e_stall = m_stall;
            if (m_init < int'(INIT_CYCLES)) begin
                e_ctrl = 8'b0000_1110;
                n_init = m_init + 1;
            end else begin
                lu = ex_memread && ex_rd != 0 &&
                     ((ex_rd == id_rs1 && id_use_rs1) || (ex_rd == id_rs2 && id_use_rs2));
                stuck = m_wait ? !(dmem_ready || m_wcnt == int'(WAIT_TIMEOUT) - 1)
                               : (mem_access && !dmem_ready);
                if (stuck)                e_ctrl = {4'b0000, 2'b00, 1'b1, mem_access};
                else if (ex_branch_taken) e_ctrl = {4'b1111, 2'b11, 1'b0, mem_access};
                else if (lu)              e_ctrl = {4'b0011, 2'b01, 1'b0, mem_access};
                else                      e_ctrl = {4'b1111, 2'b00, 1'b0, mem_access};
                if (stuck) begin
                    n_wcnt = m_wait ? m_wcnt + 1 : 0;
                    n_wait = 1;
                end else begin
                    if (m_wait && !dmem_ready) n_tmo = 1;
                    n_wait = 0;
                    n_wcnt = 0;
                end
                if (!e_ctrl[7] && m_stall != 32'hFFFF_FFFF) n_stall = m_stall + 1;
            end
        end
        check("model_ctrl", {pc_en, if_id_en, id_ex_en, ex_mem_en,
                             if_id_flush, id_ex_flush, mem_wb_bubble, dmem_req}, e_ctrl);
        check("model_fwd", {fwd_a, fwd_b}, e_fwd);
        check("model_timeout_err", timeout_err, e_tmo);
        check("model_stall_count", stall_count, e_stall);
    end

    always @(posedge clock) begin
        m_init  <= n_init;
        m_wait  <= n_wait;
        m_wcnt  <= n_wcnt;
        m_tmo   <= n_tmo;
        m_stall <= n_stall;
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_memread = 0; ex_branch_taken = 0;
        mem_rd = 0; mem_regwrite = 0; mem_access = 0; dmem_ready = 0;
        wb_rd = 0; wb_regwrite = 0;
    endtask

    logic [31:0] s0;
    int          frozen;
    bit          done;

    initial begin
        reset = 1'b0;
        idle();
        @(negedge clock);
        check("rst_pc_en", pc_en, 0);
        check("rst_bubble", mem_wb_bubble, 1);
        check("rst_flush", {if_id_flush, id_ex_flush}, 0);
        tick(); tick();
        reset = 1'b1;

        // Hold window after reset release
        for (int i = 0; i < int'(INIT_CYCLES); i++) begin
            @(negedge clock);
            check("init_pc_en", pc_en, 0);
            check("init_flush", {if_id_flush, id_ex_flush}, 2'b11);
            tick();
        end
        @(negedge clock);
        check("init_exit_pc_en", pc_en, 1);
        check("init_stall_count", stall_count, 0);
        tick();

        // Load-use on rs1
        ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        @(negedge clock);
        s0 = stall_count;
        check("lu_pc_en", pc_en, 0);
        check("lu_if_id_en", if_id_en, 0);
        check("lu_id_ex_flush", id_ex_flush, 1);
        tick(); idle();
        @(negedge clock);
        check("lu_stall_count", stall_count, s0 + 1);
        check("lu_release_pc_en", pc_en, 1);
        tick();
        ex_memread = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
        @(negedge clock);
        check("lu_rd0_pc_en", pc_en, 1);
        tick();
        ex_rd = 6; id_rs2 = 6; id_use_rs2 = 0;
        @(negedge clock);
        check("lu_unused_rs2_pc_en", pc_en, 1);
        tick();
        id_use_rs2 = 1;
        @(negedge clock);
        check("lu_rs2_pc_en", pc_en, 0);
        tick(); idle();

        // Branch masks simultaneous load-use
        ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; ex_branch_taken = 1;
        @(negedge clock);
        s0 = stall_count;
        check("br_pc_en", pc_en, 1);
        check("br_flush", {if_id_flush, id_ex_flush}, 2'b11);
        tick(); idle();
        @(negedge clock);
        check("br_stall_count", stall_count, s0);
        tick();

        // Memory wait of 3 frozen cycles with a branch pending in EX
        mem_access = 1; dmem_ready = 0; ex_branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (i == 0) s0 = stall_count;
            check("mw_pc_en", pc_en, 0);
            check("mw_bubble", mem_wb_bubble, 1);
            check("mw_req", dmem_req, 1);
            check("mw_flush", {if_id_flush, id_ex_flush}, 0);
            tick();
        end
        dmem_ready = 1;
        @(negedge clock);
        check("mw_adv_pc_en", pc_en, 1);
        check("mw_adv_bubble", mem_wb_bubble, 0);
        check("mw_adv_branch_flush", if_id_flush, 1);
        tick(); idle();
        @(negedge clock);
        check("mw_stall_count", stall_count, s0 + 3);
        check("mw_no_timeout", timeout_err, 0);
        tick();

        // Wait timeout: ready never comes
        mem_access = 1; dmem_ready = 0;
        frozen = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clock);
            if (i == 0) s0 = stall_count;
            if (pc_en) done = 1;
            else frozen++;
            if (!done) tick();
        end
        check("tmo_advanced", done, 1);
        check("tmo_frozen_cycles", frozen, 8);
        check("tmo_err_not_yet", timeout_err, 0);
        tick();
        @(negedge clock);
        check("tmo_err_set", timeout_err, 1);
        check("tmo_stall_count", stall_count, s0 + 8);
        tick(); tick();
        @(negedge clock);
        check("tmo_err_sticky", timeout_err, 1);
        check("tmo_rewait_req", dmem_req, 1);
        tick();

        // Reset mid-wait drops request at once and clears the error
        reset = 1'b0;
        #1;
        check("rst_async_req", dmem_req, 0);
        check("rst_tmo_clear", timeout_err, 0);
        check("rst_stall_clear", stall_count, 0);
        tick(); idle();
        reset = 1'b1;
        repeat (INIT_CYCLES) tick();

        // Forwarding
        mem_rd = 7; wb_rd = 7; ex_rs1 = 7; mem_regwrite = 1; wb_regwrite = 1;
        @(negedge clock);
        check("fwd_a_mem", fwd_a, 2'b10);
        tick();
        mem_regwrite = 0;
        @(negedge clock);
        check("fwd_a_wb", fwd_a, 2'b01);
        tick();
        ex_rs1 = 0;
        @(negedge clock);
        check("fwd_a_none", fwd_a, 2'b00);
        tick();
        mem_rd = 0; wb_rd = 0; ex_rs2 = 0; mem_regwrite = 1; wb_regwrite = 1;
        @(negedge clock);
        check("fwd_b_x0", fwd_b, 2'b00);
        tick();
        mem_rd = 3; mem_regwrite = 0; wb_rd = 3; ex_rs2 = 3;
        @(negedge clock);
        check("fwd_b_wb", fwd_b, 2'b01);
        tick();

        // Mixed traffic, checked by the model every cycle
        for (int i = 0; i < 80; i++) begin
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
            ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3)); ex_memread = 1'($urandom);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            mem_rd = 5'($urandom_range(0, 3)); mem_regwrite = 1'($urandom);
            mem_access = 1'($urandom); dmem_ready = ($urandom_range(0, 3) != 0);
            wb_rd = 5'($urandom_range(0, 3)); wb_regwrite = 1'($urandom);
            tick();
        end
        idle();
        tick();
        @(negedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
